// File: rtl/fp_sched_pkg.sv
// Shared definitions for the FP32 add/sub issue scheduler: data width, opcodes
// and the tag that follows each operation through the adder's latency.
package fp_sched_pkg;

   localparam int   DATA_W = 32;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

endpackage

// File: rtl/fp_sched_fifo.sv
// Per-requester result FIFO: synchronous, first-word fall-through, with an
// occupancy count. A push into an empty FIFO becomes visible the next cycle.
module fp_sched_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic                         valid,
   output logic [W-1:0]                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [AW-1:0] P_ONE = AW'(1);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign valid  = (count != '0);
   assign do_pop = pop & valid;
   // Head reads as zero when empty so nothing stale leaks out after reset.
   assign head   = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + P_ONE;
         if (do_pop) rd_ptr <= rd_ptr + P_ONE;
         if (push && !do_pop)      count <= count + C_ONE;
         else if (!push && do_pop) count <= count - C_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fp_addsub_sched.sv
// Two-requester scheduler in front of a fixed-latency, non-stalling FP32 adder:
// round-robin issue, tag pipeline matching the adder latency, per-requester FIFOs.
module fp_addsub_sched
   import fp_sched_pkg::*;
#(
   parameter int LAT   = 4,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [2*DATA_W-1:0]   req_a,
   input  logic [2*DATA_W-1:0]   req_b,
   input  logic [1:0]            req_op,
   output logic                  add_vld,
   output logic [DATA_W-1:0]     add_a,
   output logic [DATA_W-1:0]     add_b,
   output logic                  add_op,
   input  logic [DATA_W-1:0]     add_res,
   output logic [1:0]            rsp_valid,
   input  logic [1:0]            rsp_ready,
   output logic [2*DATA_W-1:0]   rsp_data
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] C_ONE = CW'(1);
   localparam logic [CW-1:0] C_MAX = CW'(DEPTH);

   logic                 rdy_en;
   logic                 last_grant;
   logic                 issue_id;
   logic [CW-1:0]        credit [2];
   logic [1:0][CW-1:0]   fifo_cnt;
   logic [1:0]           elig;
   logic [1:0]           cand;
   logic [1:0]           acc;
   logic [1:0]           pop;
   logic [1:0]           push;
   logic                 sel;
   tag_t                 tag_q [LAT];
   tag_t                 tag_out;

   // Handshake: a transfer happens in any cycle where valid and ready are both
   // high; ready may look at the other requester's valid, never the reverse.
   assign elig[0] = rdy_en & (credit[0] < C_MAX);
   assign elig[1] = rdy_en & (credit[1] < C_MAX);
   assign cand    = req_valid & elig;

   assign req_ready[0] = elig[0] & (~cand[1] | last_grant);
   assign req_ready[1] = elig[1] & (~cand[0] | ~last_grant);
   assign acc          = req_valid & req_ready;
   assign sel          = acc[1];
   assign pop          = rsp_valid & rsp_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdy_en     <= 1'b0;
         last_grant <= 1'b1;
         issue_id   <= 1'b0;
         add_vld    <= 1'b0;
         add_a      <= '0;
         add_b      <= '0;
         add_op     <= 1'b0;
      end else begin
         rdy_en  <= 1'b1;
         add_vld <= |acc;
         if (|acc) begin
            last_grant <= sel;
            issue_id   <= sel;
            add_a      <= sel ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
            add_b      <= sel ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
            add_op     <= req_op[sel];
         end
      end
   end

   // Credit reserves FIFO space at acceptance, so a returning result always fits.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         credit[0] <= '0;
         credit[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (acc[i] && !pop[i])      credit[i] <= credit[i] + C_ONE;
            else if (!acc[i] && pop[i]) credit[i] <= credit[i] - C_ONE;
         end
      end
   end

   // Stage 0 loads alongside the issue strobe; the last stage lines up with add_res.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      end else begin
         tag_q[0] <= '{valid: add_vld, id: issue_id};
         for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   assign tag_out = tag_q[LAT-1];
   assign push[0] = tag_out.valid & ~tag_out.id;
   assign push[1] = tag_out.valid &  tag_out.id;

   for (genvar g = 0; g < 2; g++) begin : g_fifo
      fp_sched_fifo #(
         .DEPTH (DEPTH),
         .W     (DATA_W)
      ) u_fifo (
         .clk       (clk),
         .rstn      (rstn),
         .push      (push[g]),
         .push_data (add_res),
         .pop       (pop[g]),
         .valid     (rsp_valid[g]),
         .head      (rsp_data[g*DATA_W +: DATA_W]),
         .count     (fifo_cnt[g])
      );

      a_cnt_le_credit : assert property (@(posedge clk) disable iff (!rstn)
         fifo_cnt[g] <= credit[g]);
   end

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched: a LAT=4 instance for arbitration, credit
// and reset behaviour, plus a LAT=1 instance for back-to-back throughput.
module tb_fp_addsub_sched;

   localparam int W     = 32;
   localparam int LAT   = 4;
   localparam int DEPTH = 4;
   localparam int LAT_U = 1;

   logic clk = 1'b0;
   logic rstn;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers and adder model ----------------
   function automatic logic [31:0] int2fp(input int n);
      logic s;
      int   m;
      int   p;
      if (n == 0) return 32'h0;
      s = (n < 0);
      m = s ? -n : n;
      p = 0;
      for (int k = 1; k < 24; k++) if ((m >> k) != 0) p = k;
      return {s, 8'(127 + p), 23'(m << (23 - p))};
   endfunction

   function automatic int fp2int(input logic [31:0] f);
      int e;
      int m;
      if (f[30:0] == 31'h0) return 0;
      e = int'(f[30:23]) - 127;
      m = int'({1'b1, f[22:0]}) >> (23 - e);
      return f[31] ? -m : m;
   endfunction

   function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
      return int2fp(op ? fp2int(a) - fp2int(b) : fp2int(a) + fp2int(b));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- main DUT (LAT=4) ----------------
   logic [1:0]  req_valid, req_ready, req_op, rsp_valid, rsp_ready;
   logic [63:0] req_a, req_b, rsp_data;
   logic        add_vld, add_op;
   logic [31:0] add_a, add_b, add_res;
   int          idx0, idx1;
   logic        acc_flag0, acc_flag1;

   assign req_a  = {int2fp(idx1 + 17), int2fp(idx0 + 1)};
   assign req_b  = {int2fp(3), int2fp(2)};
   assign req_op = {idx1[0], idx0[0]};

   fp_addsub_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .add_vld(add_vld), .add_a(add_a), .add_b(add_b), .add_op(add_op),
      .add_res(add_res),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
   );

   logic [31:0] res_pipe [LAT];
   always @(posedge clk) begin
      res_pipe[0] <= fp_model(add_a, add_b, add_op);
      for (int k = 1; k < LAT; k++) res_pipe[k] <= res_pipe[k-1];
   end
   assign add_res = res_pipe[LAT-1];

   // ---------------- LAT=1 DUT ----------------
   logic [1:0]  req_valid_u, req_ready_u, req_op_u, rsp_valid_u, rsp_ready_u;
   logic [63:0] req_a_u, req_b_u, rsp_data_u;
   logic        add_vld_u, add_op_u;
   logic [31:0] add_a_u, add_b_u, add_res_u;
   int          idx_u;
   logic        acc_flag_u;

   assign req_a_u  = {32'h0, int2fp(idx_u + 1)};
   assign req_b_u  = {32'h0, int2fp(7)};
   assign req_op_u = {1'b0, idx_u[0]};

   fp_addsub_sched #(.LAT(LAT_U), .DEPTH(DEPTH)) dut_u (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid_u), .req_ready(req_ready_u),
      .req_a(req_a_u), .req_b(req_b_u), .req_op(req_op_u),
      .add_vld(add_vld_u), .add_a(add_a_u), .add_b(add_b_u), .add_op(add_op_u),
      .add_res(add_res_u),
      .rsp_valid(rsp_valid_u), .rsp_ready(rsp_ready_u), .rsp_data(rsp_data_u)
   );

   logic [31:0] res_pipe_u [LAT_U];
   always @(posedge clk) begin
      res_pipe_u[0] <= fp_model(add_a_u, add_b_u, add_op_u);
      for (int k = 1; k < LAT_U; k++) res_pipe_u[k] <= res_pipe_u[k-1];
   end
   assign add_res_u = res_pipe_u[LAT_U-1];

   // ---------------- scoreboards ----------------
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   logic [W-1:0] exp_q_u[$];
   int grant_q[$];
   int acc_cnt [2];
   int pop_cnt [2];
   int outst [2];
   int peak1;
   int acc_u, pop_u, first_acc_u, last_acc_u, first_pop_u, last_pop_u;

   always @(negedge clk) begin
      if (rstn) begin
         if ((req_valid & req_ready) != 2'b00)
            chk("acc_onehot", 32'($countones(req_valid & req_ready)), 1);
         if (req_valid[0] && req_ready[0]) begin
            exp_q0.push_back(fp_model(req_a[31:0], req_b[31:0], req_op[0]));
            grant_q.push_back(0);
            acc_flag0 = 1'b1;
            acc_cnt[0]++;
            outst[0]++;
         end
         if (req_valid[1] && req_ready[1]) begin
            exp_q1.push_back(fp_model(req_a[63:32], req_b[63:32], req_op[1]));
            grant_q.push_back(1);
            acc_flag1 = 1'b1;
            acc_cnt[1]++;
            outst[1]++;
         end
         if (rsp_valid[0] && rsp_ready[0]) begin
            if (exp_q0.size() == 0) chk("rsp0_unexpected", 1, 0);
            else chk("rsp0_data", rsp_data[31:0], exp_q0.pop_front());
            pop_cnt[0]++;
            outst[0]--;
         end
         if (rsp_valid[1] && rsp_ready[1]) begin
            if (exp_q1.size() == 0) chk("rsp1_unexpected", 1, 0);
            else chk("rsp1_data", rsp_data[63:32], exp_q1.pop_front());
            pop_cnt[1]++;
            outst[1]--;
         end
         if (outst[1] > peak1) peak1 = outst[1];

         if (req_valid_u[0] && req_ready_u[0]) begin
            exp_q_u.push_back(fp_model(req_a_u[31:0], req_b_u[31:0], req_op_u[0]));
            if (acc_u == 0) first_acc_u = cyc;
            last_acc_u = cyc;
            acc_u++;
            acc_flag_u = 1'b1;
         end
         if (rsp_valid_u[0] && rsp_ready_u[0]) begin
            if (exp_q_u.size() == 0) chk("u_rsp_unexpected", 1, 0);
            else chk("u_rsp_data", rsp_data_u[31:0], exp_q_u.pop_front());
            if (pop_u == 0) first_pop_u = cyc;
            last_pop_u = cyc;
            pop_u++;
         end
      end
   end

   // Operand driver: step to the next vector after each acceptance.
   always @(posedge clk) begin
      #1;
      if (acc_flag0)  begin idx0++;  acc_flag0  = 1'b0; end
      if (acc_flag1)  begin idx1++;  acc_flag1  = 1'b0; end
      if (acc_flag_u) begin idx_u++; acc_flag_u = 1'b0; end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_counts();
      grant_q.delete();
      for (int i = 0; i < 2; i++) begin
         acc_cnt[i] = 0;
         pop_cnt[i] = 0;
         outst[i]   = 0;
      end
      peak1 = 0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) tick();
      #2;
      exp_q0.delete();
      exp_q1.delete();
      exp_q_u.delete();
      clear_counts();
      idx0 = 0; idx1 = 0; idx_u = 0;
      acc_flag0 = 1'b0; acc_flag1 = 1'b0; acc_flag_u = 1'b0;
      acc_u = 0; pop_u = 0;
      first_acc_u = 0; last_acc_u = 0; first_pop_u = 0; last_pop_u = 0;
      tick();
      rstn = 1'b1;
      repeat (2) tick();
   endtask

   task automatic wait_total(input int n, input int budget, input string tag);
      int c;
      c = 0;
      while ((acc_cnt[0] + acc_cnt[1]) < n && c < budget) begin
         tick();
         c++;
      end
      chk(tag, 32'((acc_cnt[0] + acc_cnt[1]) >= n), 1);
   endtask

   task automatic drain(input string tag);
      int c;
      c = 0;
      while ((exp_q0.size() + exp_q1.size()) != 0 && c < 60) begin
         tick();
         c++;
      end
      chk(tag, 32'(exp_q0.size() + exp_q1.size()), 0);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_req_ready"}, 32'(req_ready), 0);
      chk({pfx, "_add_vld"},   32'(add_vld), 0);
      chk({pfx, "_add_a"},     add_a, 0);
      chk({pfx, "_add_b"},     add_b, 0);
      chk({pfx, "_add_op"},    32'(add_op), 0);
      chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
      chk({pfx, "_rsp_data0"}, rsp_data[31:0], 0);
      chk({pfx, "_rsp_data1"}, rsp_data[63:32], 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int a0, p0, nz, seen, c;
      rstn        = 1'b0;
      req_valid   = 2'b00;
      rsp_ready   = 2'b00;
      req_valid_u = 2'b00;
      rsp_ready_u = 2'b11;
      idx0 = 0; idx1 = 0; idx_u = 0;
      acc_flag0 = 1'b0; acc_flag1 = 1'b0; acc_flag_u = 1'b0;
      #2;
      chk_reset_outputs("rst");
      do_reset();

      // Round robin: both requesters valid, requester 0 wins the first tie.
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      wait_total(8, 40, "rr_timeout");
      req_valid = 2'b00;
      for (int k = 0; k < 8; k++)
         if (k < grant_q.size()) chk($sformatf("rr_grant%0d", k), grant_q[k], k % 2);
      drain("rr_drain");
      chk("rr_pops0", pop_cnt[0], 4);
      chk("rr_pops1", pop_cnt[1], 4);

      // Requester 1 backpressured: exactly DEPTH accepts, then only requester 0.
      clear_counts();
      rsp_ready = 2'b01;
      req_valid = 2'b11;
      repeat (24) tick();
      chk("bp_acc1", acc_cnt[1], DEPTH);
      chk("bp_ready1", 32'(req_ready[1]), 0);
      chk("bp_peak1", peak1, DEPTH);
      chk("bp_acc0_ge8", 32'(acc_cnt[0] >= 8), 1);
      nz = 0;
      for (int j = 0; j < 8; j++)
         if (grant_q.size() > j && grant_q[grant_q.size() - 1 - j] != 0) nz++;
      chk("bp_tail_req0", nz, 0);

      // Full FIFO[1] released with requester 1 still valid.
      req_valid = 2'b10;
      rsp_ready = 2'b11;
      a0 = acc_cnt[1];
      p0 = pop_cnt[1];
      repeat (20) tick();
      req_valid = 2'b00;
      chk("fl_acc_win", 32'((acc_cnt[1] - a0) >= 8), 1);
      chk("fl_pop_win", 32'((pop_cnt[1] - p0) >= 8), 1);
      chk("fl_peak1", peak1, DEPTH);
      drain("fl_drain");
      chk("fl_total1", pop_cnt[1], acc_cnt[1]);

      // Single operation: 1.0 + 2.0 with exact issue and response timing.
      do_reset();
      rsp_ready = 2'b00;
      req_valid = 2'b01;
      wait_total(1, 10, "sg_timeout");
      req_valid = 2'b00;
      chk("sg_add_vld", 32'(add_vld), 1);
      chk("sg_add_a", add_a, 32'h3F800000);
      chk("sg_add_b", add_b, 32'h40000000);
      chk("sg_add_op", 32'(add_op), 0);
      repeat (LAT) tick();
      chk("sg_rsp_early", 32'(rsp_valid[0]), 0);
      tick();
      chk("sg_rsp_valid", 32'(rsp_valid[0]), 1);
      chk("sg_rsp_data", rsp_data[31:0], 32'h40400000);
      chk("sg_add_vld_low", 32'(add_vld), 0);
      chk("sg_add_a_hold", add_a, 32'h3F800000);
      rsp_ready = 2'b01;
      repeat (2) tick();
      chk("sg_drained", 32'(rsp_valid[0]), 0);

      // Reset with three operations in flight.
      rsp_ready = 2'b00;
      clear_counts();
      req_valid = 2'b01;
      wait_total(3, 20, "rs_timeout");
      req_valid = 2'b00;
      tick();
      rstn = 1'b0;
      #1;
      chk_reset_outputs("rs");
      do_reset();
      rsp_ready = 2'b11;
      seen = 0;
      repeat (2 * LAT + 2) begin
         tick();
         if (rsp_valid != 2'b00) seen++;
      end
      chk("rs_no_rsp", seen, 0);

      // LAT=1 instance: 16 back-to-back operations from requester 0.
      req_valid_u = 2'b01;
      c = 0;
      while (acc_u < 16 && c < 60) begin
         tick();
         c++;
      end
      req_valid_u = 2'b00;
      chk("u_acc_count", 32'(acc_u >= 16), 1);
      repeat (10) tick();
      chk("u_acc_span", last_acc_u - first_acc_u, 15);
      chk("u_pop_count", pop_u, 16);
      chk("u_pop_span", last_pop_u - first_pop_u, 15);
      chk("u_latency", first_pop_u - first_acc_u, LAT_U + 2);
      chk("u_q_empty", exp_q_u.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
